// File: rtl/conv_pkg.sv
// ----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution output path: DSP result width,
// requantised output width, saturation limits, the collector FSM encoding and
// a saturating narrow helper.
// ----------------------------------------------------------------------------
package conv_pkg;

  localparam int DSP_P_W = 48;
  localparam int OUT_W   = 16;

  localparam logic signed [OUT_W-1:0] OUT_MAX = 16'sh7FFF;
  localparam logic signed [OUT_W-1:0] OUT_MIN = 16'sh8000;

  // Saturation limits held at the full working width so the compare never wraps
  localparam logic signed [DSP_P_W:0] SAT_HI = 49'sd32767;
  localparam logic signed [DSP_P_W:0] SAT_LO = -49'sd32768;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } collector_state_e;

  // Clamp a working-width value into the signed output range
  function automatic logic signed [OUT_W-1:0] sat_to_out(input logic signed [DSP_P_W:0] v);
    logic signed [OUT_W-1:0] res;
    if (v > SAT_HI)      res = OUT_MAX;
    else if (v < SAT_LO) res = OUT_MIN;
    else                 res = v[OUT_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/conv_out_collector_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is presented on
// o_rd_data whenever o_empty is low; i_rd_en pops it. A write while full is
// accepted only if a pop happens in the same cycle.
// Ports:
//   i_clk, i_rst_n      clock / asynchronous active-low reset
//   i_wr_en, i_wr_data  push request and data
//   i_rd_en             pop request (ignored when empty)
//   o_rd_data           head entry (zero when empty)
//   o_full, o_empty     occupancy flags
// ----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  assign o_full   = (r_count == FULL_CNT);
  assign o_empty  = (r_count == '0);
  assign w_do_rd  = i_rd_en & ~o_empty;
  // A simultaneous pop frees the slot, so a write into a full FIFO still lands
  assign w_do_wr  = i_wr_en & (~o_full | w_do_rd);

  // Head entry is forced to zero when empty so the outputs are clean after reset
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/conv_out_collector.sv
// ----------------------------------------------------------------------------
// conv_out_collector
// Output stage behind the DSP-cascade convolution PE. Tracks the window
// position of every PE result, keeps only positions whose window does not
// wrap a row edge, requantises kept results to 16-bit signed (round, shift,
// saturate) and queues them in a FIFO feeding a valid/ready writer port.
// The PE cannot stall, so a full FIFO drops the sample and raises o_ovf.
// Build option: CONV_OUT_RELU_EN forces negative results to zero after
// saturation.
// Ports:
//   i_clk, i_rst_n        clock / asynchronous active-low reset
//   i_valid, i_P          PE result stream
//   i_clr                 clears the sticky o_ovf / o_err flags
//   o_data, o_valid, o_last, i_ready   downstream valid/ready port
//   o_frame_done          pulse when the last kept position is captured
//   o_ovf                 sticky: kept sample lost to a full FIFO
//   o_err                 sticky: i_valid dropped mid-frame
// ----------------------------------------------------------------------------
module conv_out_collector
  import conv_pkg::*;
#(
  parameter int FM_SIZE     = 4,
  parameter int KERNEL_SIZE = 2,
  parameter int SHIFT       = 4,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  input  logic signed [DSP_P_W-1:0] i_P,
  input  logic                      i_clr,
  output logic signed [OUT_W-1:0]   o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_last,
  output logic                      o_frame_done,
  output logic                      o_ovf,
  output logic                      o_err
);

  localparam int CW = (FM_SIZE > 1) ? $clog2(FM_SIZE) : 1;
  localparam logic [CW-1:0] LAST_POS = CW'(FM_SIZE - KERNEL_SIZE);
  localparam logic [CW-1:0] LAST_COL = CW'(FM_SIZE - 1);
  localparam logic signed [DSP_P_W:0] ROUND =
    (SHIFT == 0) ? '0 : (49'sd1 <<< ((SHIFT == 0) ? 0 : SHIFT - 1));

  collector_state_e r_state, w_state_nxt;
  logic [CW-1:0]    r_row, r_col, w_row_nxt, w_col_nxt;
  logic             w_keep, w_last, w_err_set;

  logic signed [DSP_P_W:0] w_sum, w_shifted;
  logic signed [OUT_W-1:0] w_sat, w_res;

  logic             r_q_valid, r_q_last, r_frame_done, r_ovf, r_err;
  logic [OUT_W-1:0] r_q_data;
  logic [OUT_W:0]   w_rd_data;
  logic             w_full, w_empty, w_drop;

  // IDLE treats a valid sample as position (0,0) because the counters rest at zero
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_keep      = 1'b0;
    w_last      = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE, ST_RUN: begin
        if (i_valid) begin
          w_keep = (r_col <= LAST_POS) && (r_row <= LAST_POS);
          w_last = w_keep && (r_col == LAST_POS) && (r_row == LAST_POS);
          if (w_last) begin
            w_state_nxt = ST_DONE;
            w_row_nxt   = '0;
            w_col_nxt   = '0;
          end else begin
            w_state_nxt = ST_RUN;
            if (r_col == LAST_COL) begin
              w_col_nxt = '0;
              w_row_nxt = r_row + 1'b1;
            end else begin
              w_col_nxt = r_col + 1'b1;
            end
          end
        end else if (r_state == ST_RUN) begin
          w_err_set   = 1'b1;
          w_state_nxt = ST_IDLE;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
        end
      end
      ST_DONE: begin
        if (!i_valid) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
    end
  end

  // Round-half-up then arithmetic shift, one bit wider than P so nothing wraps
  assign w_sum     = {i_P[DSP_P_W-1], i_P} + ROUND;
  assign w_shifted = w_sum >>> SHIFT;
  assign w_sat     = sat_to_out(w_shifted);
`ifdef CONV_OUT_RELU_EN
  assign w_res     = w_sat[OUT_W-1] ? '0 : w_sat;
`else
  assign w_res     = w_sat;
`endif

  // A dropped write can only happen when full and the head is not being popped
  assign w_drop = r_q_valid & w_full & ~i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q_valid    <= 1'b0;
      r_q_last     <= 1'b0;
      r_q_data     <= '0;
      r_frame_done <= 1'b0;
      r_ovf        <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_q_valid    <= w_keep;
      r_q_last     <= w_last;
      r_q_data     <= w_res;
      r_frame_done <= w_last;
      r_ovf        <= (r_ovf & ~i_clr) | w_drop;
      r_err        <= (r_err & ~i_clr) | w_err_set;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (r_q_valid),
    .i_wr_data ({r_q_last, r_q_data}),
    .i_rd_en   (i_ready),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign o_valid      = ~w_empty;
  assign o_data       = w_rd_data[OUT_W-1:0];
  assign o_last       = w_rd_data[OUT_W];
  assign o_frame_done = r_frame_done;
  assign o_ovf        = r_ovf;
  assign o_err        = r_err;

endmodule

// File: tb/tb_conv_out_collector.sv
// Testbench for conv_out_collector. Three instances share clock/reset:
//   A: FM=4 K=2 SHIFT=0 depth 4  (frame order, overflow, error, reset)
//   B: FM=1 K=1 SHIFT=4 depth 4  (every sample is a frame: requant values)
//   C: FM=3 K=3 SHIFT=0 depth 4  (single-sample frame)
// Expected words are queued when stimulus is driven and popped by per-instance
// monitors on the negative edge when a transfer is about to happen.
module tb_conv_out_collector;

   logic clk = 1'b0;
   logic rstN;
   logic clr;

   logic               vInA, vInB, vInC;
   logic signed [47:0] pA, pB, pC;
   logic               readyA, readyB, readyC;
   logic signed [15:0] dataA, dataB, dataC;
   logic               vA, vB, vC, lastA, lastB, lastC;
   logic               fdA, fdB, fdC, ovfA, ovfB, ovfC, errA, errB, errC;

   logic [16:0] qA[$];
   logic [16:0] qB[$];
   logic [16:0] qC[$];

   int testCount = 0;
   int failCount = 0;

   always #5 clk = ~clk;

   conv_out_collector #(.FM_SIZE(4), .KERNEL_SIZE(2), .SHIFT(0), .FIFO_DEPTH(4)) dutA (
      .i_clk(clk), .i_rst_n(rstN), .i_valid(vInA), .i_P(pA), .i_clr(clr),
      .o_data(dataA), .o_valid(vA), .i_ready(readyA), .o_last(lastA),
      .o_frame_done(fdA), .o_ovf(ovfA), .o_err(errA));

   conv_out_collector #(.FM_SIZE(1), .KERNEL_SIZE(1), .SHIFT(4), .FIFO_DEPTH(4)) dutB (
      .i_clk(clk), .i_rst_n(rstN), .i_valid(vInB), .i_P(pB), .i_clr(clr),
      .o_data(dataB), .o_valid(vB), .i_ready(readyB), .o_last(lastB),
      .o_frame_done(fdB), .o_ovf(ovfB), .o_err(errB));

   conv_out_collector #(.FM_SIZE(3), .KERNEL_SIZE(3), .SHIFT(0), .FIFO_DEPTH(4)) dutC (
      .i_clk(clk), .i_rst_n(rstN), .i_valid(vInC), .i_P(pC), .i_clr(clr),
      .o_data(dataC), .o_valid(vC), .i_ready(readyC), .o_last(lastC),
      .o_frame_done(fdC), .o_ovf(ovfC), .o_err(errC));

   // Central comparison point: counts every check and reports failures
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected result for a negative value depends on the ReLU build option
   function automatic int reluModel(input int v);
`ifdef CONV_OUT_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   // Monitors compare the head word whenever a transfer is about to happen
   always @(negedge clk) begin : monA
      logic [16:0] e;
      if (rstN && vA && readyA) begin
         if (qA.size() == 0) checkOutput("A_spurious_valid", 64'(vA), 64'd0);
         else begin
            e = qA.pop_front();
            checkOutput("A_last_data", 64'({lastA, dataA}), 64'(e));
         end
      end
   end

   always @(negedge clk) begin : monB
      logic [16:0] e;
      if (rstN && vB && readyB) begin
         if (qB.size() == 0) checkOutput("B_spurious_valid", 64'(vB), 64'd0);
         else begin
            e = qB.pop_front();
            checkOutput("B_last_data", 64'({lastB, dataB}), 64'(e));
         end
      end
   end

   always @(negedge clk) begin : monC
      logic [16:0] e;
      if (rstN && vC && readyC) begin
         if (qC.size() == 0) checkOutput("C_spurious_valid", 64'(vC), 64'd0);
         else begin
            e = qC.pop_front();
            checkOutput("C_last_data", 64'({lastC, dataC}), 64'(e));
         end
      end
   end

   // Streams n samples P=offset+k into instance A, queuing up to pushLimit kept
   // results, checking the frame-done pulse, then drops i_valid
   task automatic applyStimulus(input int n, input int offset, input int pushLimit);
      int pushed = 0;
      for (int k = 0; k <= n; k++) begin
         @(posedge clk); #1;
         if (k >= 1) checkOutput("A_frame_done", 64'(fdA), 64'((k - 1) == 10));
         if (k < n) begin
            vInA = 1'b1;
            pA   = 48'(offset + k);
            if (k <= 10 && (k / 4) <= 2 && (k % 4) <= 2 && pushed < pushLimit) begin
               qA.push_back({(k == 10), 16'(offset + k)});
               pushed++;
            end
         end else begin
            vInA = 1'b0;
         end
      end
      @(posedge clk); #1;
   endtask

   function automatic int qSize(input int sel);
      case (sel)
         0:       return qA.size();
         1:       return qB.size();
         default: return qC.size();
      endcase
   endfunction

   // Bounded wait for a scoreboard queue to empty
   task automatic waitDrain(input int sel, input string tag);
      for (int i = 0; i < 100 && qSize(sel) != 0; i++) @(posedge clk);
      #1;
      checkOutput(tag, 64'(qSize(sel)), 64'd0);
   endtask

   longint pTab[9] = '{40, -40, 64'sd1 <<< 40, -(64'sd1 <<< 40), 7, -9, 524279, 524280, -524297};
   int     eTab[9] = '{3, -2, 32767, -32768, 0, -1, 32767, 32767, -32768};

   initial begin
      rstN = 1'b0; clr = 1'b0;
      vInA = 1'b0; vInB = 1'b0; vInC = 1'b0;
      pA = '0; pB = '0; pC = '0;
      readyA = 1'b1; readyB = 1'b1; readyC = 1'b1;

      // Reset state
      #3;
      checkOutput("A_rst_valid", 64'(vA), 64'd0);
      checkOutput("A_rst_data", 64'(dataA), 64'd0);
      checkOutput("A_rst_last", 64'(lastA), 64'd0);
      checkOutput("A_rst_fd", 64'(fdA), 64'd0);
      checkOutput("A_rst_flags", 64'({ovfA, errA}), 64'd0);
      #19 rstN = 1'b1;

      // Main frame: outputs 0,1,2,4,5,6,8,9,10 with last on 10
      applyStimulus(16, 0, 99);
      waitDrain(0, "A_frame_drain");
      checkOutput("A_no_flags", 64'({ovfA, errA}), 64'd0);

      // Overflow: no reads for a full frame, only the first 4 kept results survive
      readyA = 1'b0;
      applyStimulus(16, 0, 4);
      checkOutput("A_ovf_set", 64'(ovfA), 64'd1);
      checkOutput("A_ovf_held_valid", 64'(vA), 64'd1);
      @(posedge clk); #1 clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
      checkOutput("A_ovf_cleared", 64'(ovfA), 64'd0);
      readyA = 1'b1;
      waitDrain(0, "A_ovf_drain");
      repeat (3) @(posedge clk);
      #1 checkOutput("A_ovf_empty", 64'(vA), 64'd0);

      // Error: i_valid falls after 5 samples, next frame restarts at (0,0)
      applyStimulus(5, 0, 99);
      checkOutput("A_err_set", 64'(errA), 64'd1);
      applyStimulus(16, 100, 99);
      waitDrain(0, "A_err_restart_drain");
      checkOutput("A_err_sticky", 64'(errA), 64'd1);
      @(posedge clk); #1 clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
      checkOutput("A_err_cleared", 64'(errA), 64'd0);

      // Requantisation with SHIFT=4: every sample is its own frame on instance B
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
         vInB = 1'b1;
         pB   = 48'(pTab[i]);
         qB.push_back({1'b1, 16'(reluModel(eTab[i]))});
         @(posedge clk); #1;
         checkOutput("B_frame_done", 64'(fdB), 64'd1);
         vInB = 1'b0;
         @(posedge clk);
      end
      waitDrain(1, "B_drain");

      // Single-sample frame: K == FM
      @(posedge clk); #1;
      vInC = 1'b1; pC = 48'sd100;
      qC.push_back({1'b1, 16'd100});
      @(posedge clk); #1;
      checkOutput("C_frame_done", 64'(fdC), 64'd1);
      vInC = 1'b0;
      @(posedge clk); #1;
      checkOutput("C_fd_pulse_end", 64'(fdC), 64'd0);
      vInC = 1'b1; pC = -48'sd5;
      qC.push_back({1'b1, 16'(reluModel(-5))});
      @(posedge clk); #1 vInC = 1'b0;
      waitDrain(2, "C_drain");

      // Asynchronous reset mid-frame with queued results
      readyA = 1'b0;
      for (int k = 0; k < 11; k++) begin
         @(posedge clk); #1;
         vInA = 1'b1; pA = 48'(k);
      end
      #2 rstN = 1'b0;
      #1;
      checkOutput("A_rst_mid_valid", 64'(vA), 64'd0);
      checkOutput("A_rst_mid_fd", 64'(fdA), 64'd0);
      qA.delete();
      vInA = 1'b0;
      #10 rstN = 1'b1;
      readyA = 1'b1;
      applyStimulus(16, 200, 99);
      waitDrain(0, "A_post_reset_drain");
      checkOutput("A_post_reset_flags", 64'({ovfA, errA}), 64'd0);

      repeat (4) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

   // Global time bound so the bench can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
